pgm_vram_arbiter: RTL

PGM_VRAM_ARBITER -- requirements
Module: pgm_vram_arbiter

---
 rtl/pgm_vram_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pgm_vram_arbiter.sv
// VRAM port arbiter: shares one single-port RAM between the 68k CPU and the
// renderer. The renderer gets the port whenever the CPU is not using it, and
// may delay a pending CPU access for at most STARVE_MAX consecutive grants.
module pgm_vram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 3
) (
    input  logic              fixed_20m_clk,
    input  logic              reset_n,
    input  logic              cpu_as_n,
    input  logic              cpu_uds_n,
    input  logic              cpu_lds_n,
    input  logic              cpu_rw_n,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [15:0]       cpu_dout,
    output logic [15:0]       cpu_din,
    output logic              cpu_dtack_n,
    input  logic              ren_req,
    input  logic [ADDR_W-1:0] ren_addr,
    output logic              ren_ack,
    output logic              ren_valid,
    output logic [15:0]       ren_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we_hi,
    output logic              ram_we_lo,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        CPU_DATA = 2'd2,
        CPU_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              dtack_n_q, dtack_n_d;
    logic [15:0]       din_q, din_d;
    logic              ren_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cpu_pend;
    logic              ren_grant;

    // Next-state, grant and RAM port steering
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        dtack_n_d = dtack_n_q;
        din_d     = din_q;
        ren_grant = 1'b0;
        ram_addr  = addr_q;
        ram_we_hi = 1'b0;
        ram_we_lo = 1'b0;
        // Only IDLE can accept a new access; HOLD is left only once AS rises,
        // so a low strobe seen in IDLE is always an unserved request.
        cpu_pend  = !cpu_as_n && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (cpu_pend) begin
                    if (ren_req && (starve_q < STARVE_LIM)) begin
                        ren_grant = 1'b1;
                        starve_d  = starve_q + CNT_W'(1);
                    end else begin
                        state_d  = CPU_ACC;
                        starve_d = '0;
                    end
                end else begin
                    // Abort or no CPU activity: forget any accumulated starvation
                    starve_d  = '0;
                    ren_grant = ren_req;
                end
            end
            CPU_ACC: begin
                ram_addr  = cpu_adr;
                ram_we_hi = !cpu_rw_n && !cpu_uds_n;
                ram_we_lo = !cpu_rw_n && !cpu_lds_n;
                state_d   = CPU_DATA;
            end
            CPU_DATA: begin
                ren_grant = ren_req;
                din_d     = ram_rdata;
                if (cpu_as_n) begin
                    // CPU went away mid-access: finish quietly, no DTACK
                    dtack_n_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                    state_d   = CPU_HOLD;
                end
            end
            CPU_HOLD: begin
                ren_grant = ren_req;
                if (cpu_as_n) begin
                    dtack_n_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ren_grant) begin
            ram_addr = ren_addr;
        end
    end

    // State, counters and registered CPU/renderer outputs
    always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            dtack_n_q   <= 1'b1;
            din_q       <= 16'h0000;
            ren_valid_q <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            dtack_n_q   <= dtack_n_d;
            din_q       <= din_d;
            ren_valid_q <= ren_grant;
            addr_q      <= ram_addr;
        end
    end

    assign ren_ack     = ren_grant;
    assign ren_valid   = ren_valid_q;
    assign ren_data    = ram_rdata;
    assign ram_wdata   = cpu_dout;
    assign cpu_din     = din_q;
    assign cpu_dtack_n = dtack_n_q;

endmodule
